// File: rtl/ahb_lite_master_adapter.sv
// ahb_lite_master_adapter
//   AHB-Lite initiator fed by a valid/ready request port. Each accepted request
//   becomes one SINGLE transfer; address and data phases are pipelined so one
//   transfer per cycle is possible. Responses return in request order.
//
// Ports
//   HCLK, HRESET          clock, asynchronous active-high reset
//   req_valid/req_ready   request handshake (req_ready is combinational)
//   req_addr/write/size   request address, direction, HSIZE encoding
//   req_nonsec/req_wdata  security attribute, lane-aligned write data
//   rsp_valid/err/rdata   registered one-cycle response pulse, no backpressure
//   HADDR..HWDATA         AHB-Lite manager outputs (HBURST tied SINGLE)
//   HRDATA/HREADY/HRESP   AHB-Lite manager inputs
module ahb_lite_master_adapter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BYTE_COUNT = DATA_WIDTH / 8,
  parameter logic        SEC_TRANS  = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic                  req_nonsec,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic                  HNONSEC,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam int unsigned SIZE_MAX  = $clog2(BYTE_COUNT);
  localparam logic [1:0]  TR_IDLE   = 2'b00;
  localparam logic [1:0]  TR_NONSEQ = 2'b10;

  // Elaboration-time guard on the bus width.
  if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "ahb_lite_master_adapter: DATA_WIDTH must be a power of two in 8..1024");
  end

  // Address slot A
  logic                  r_a_vld;
  logic                  r_a_tok;
  logic                  r_a_write;
  logic [DATA_WIDTH-1:0] r_a_wdata;
  logic [ADDR_WIDTH-1:0] r_haddr;
  logic [1:0]            r_htrans;
  logic                  r_hwrite;
  logic [2:0]            r_hsize;
  logic                  r_hnonsec;
  // Data slot D
  logic                  r_d_vld;
  logic                  r_d_tok;
  logic                  r_d_write;
  logic [DATA_WIDTH-1:0] r_hwdata;
  // Response
  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_accept;
  logic                  w_reject;
  logic                  w_complete;
  logic [ADDR_WIDTH-1:0] w_align_mask;

  // Request rejected locally: size wider than the bus or address not size-aligned.
  assign w_align_mask = (ADDR_WIDTH'(1) << req_size) - ADDR_WIDTH'(1);
  assign w_reject     = (32'(req_size) > SIZE_MAX) || ((req_addr & w_align_mask) != '0);

  assign req_ready  = !HRESET && (!r_a_vld || HREADY);
  assign w_accept   = req_valid && req_ready;
  assign w_complete = HREADY && r_d_vld;

  // Slot A: reloads whenever it advances, or when empty during a wait state.
  // Error tokens occupy the slot but leave the bus IDLE and the address outputs untouched.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_a_vld   <= 1'b0;
      r_a_tok   <= 1'b0;
      r_a_write <= 1'b0;
      r_a_wdata <= '0;
      r_haddr   <= '0;
      r_htrans  <= TR_IDLE;
      r_hwrite  <= 1'b0;
      r_hsize   <= 3'b000;
      r_hnonsec <= 1'b0;
    end else if (HREADY || !r_a_vld) begin
      if (w_accept) begin
        r_a_vld   <= 1'b1;
        r_a_tok   <= w_reject;
        r_a_write <= req_write;
        r_a_wdata <= req_wdata;
        r_htrans  <= w_reject ? TR_IDLE : TR_NONSEQ;
        if (!w_reject) begin
          r_haddr   <= req_addr;
          r_hwrite  <= req_write;
          r_hsize   <= req_size;
          r_hnonsec <= SEC_TRANS ? req_nonsec : 1'b0;
        end
      end else begin
        r_a_vld  <= 1'b0;
        r_a_tok  <= 1'b0;
        r_htrans <= TR_IDLE;
      end
    end
  end

  // Slot D: takes over slot A on every completing edge.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_d_vld   <= 1'b0;
      r_d_tok   <= 1'b0;
      r_d_write <= 1'b0;
      r_hwdata  <= '0;
    end else if (HREADY) begin
      r_d_vld   <= r_a_vld;
      r_d_tok   <= r_a_tok;
      r_d_write <= r_a_write;
      if (r_a_vld && r_a_write && !r_a_tok) begin
        r_hwdata <= r_a_wdata;
      end
    end
  end

  // Response register: read data only surfaces for an OKAY bus read.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_complete;
      if (w_complete) begin
        r_rsp_err   <= HRESP || r_d_tok;
        r_rsp_rdata <= (!r_d_write && !r_d_tok && !HRESP) ? HRDATA : '0;
      end else begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign HADDR     = r_haddr;
  assign HTRANS    = r_htrans;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HBURST    = 3'b000;
  assign HNONSEC   = r_hnonsec;
  assign HWDATA    = r_hwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_ahb_lite_master_adapter.sv
// Bench for ahb_lite_master_adapter: directed vector table, hand sequences for
// wait/error/reset corners, then a random run against a transaction-level model.
module tb_ahb_lite_master_adapter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [2:0]    req_size;
  logic          req_nonsec;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic          HNONSEC;
  logic [DW-1:0] HWDATA;
  logic [DW-1:0] HRDATA;
  logic          HREADY;
  logic          HRESP;

  ahb_lite_master_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_nonsec(req_nonsec),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HNONSEC(HNONSEC), .HWDATA(HWDATA),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] hrdata;
    logic        exp_bus;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    int          waits;
  } bus_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  vec_t vecs[8];
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  task automatic drive_req(input logic [31:0] a, input logic w, input logic [2:0] s, input logic [31:0] d);
    req_valid  = 1'b1;
    req_addr   = a;
    req_write  = w;
    req_size   = s;
    req_wdata  = d;
    req_nonsec = 1'b1;
  endtask

  task automatic bus_okay();
    HREADY = 1'b1;
    HRESP  = 1'b0;
    HRDATA = '0;
  endtask

  // One isolated request with a zero-wait slave; checks exact cycle placement.
  task automatic run_vec(input vec_t v, input string tag);
    @(negedge HCLK);
    bus_okay();
    drive_req(v.addr, v.write, v.size, v.wdata);
    #1 chk({tag, "_ready"}, 64'(req_ready), 64'(1));
    @(negedge HCLK);
    req_valid = 1'b0;
    chk({tag, "_htrans"}, 64'(HTRANS), v.exp_bus ? 64'(2) : 64'(0));
    if (v.exp_bus) begin
      chk({tag, "_haddr"}, 64'(HADDR), 64'(v.addr));
      chk({tag, "_hwrite"}, 64'(HWRITE), 64'(v.write));
      chk({tag, "_hsize"}, 64'(HSIZE), 64'(v.size));
    end
    @(negedge HCLK);
    HRDATA = v.hrdata;
    chk({tag, "_dphase_rsp"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_dphase_htrans"}, 64'(HTRANS), 64'(0));
    if (v.exp_bus && v.write) chk({tag, "_hwdata"}, 64'(HWDATA), 64'(v.wdata));
    @(negedge HCLK);
    HRDATA = '0;
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(1));
    chk({tag, "_rsp_err"}, 64'(rsp_err), 64'(v.exp_err));
    chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    @(negedge HCLK);
    chk({tag, "_rsp_pulse"}, 64'(rsp_valid), 64'(0));
  endtask

  initial begin
    vecs[0] = '{32'h100, 1'b0, 3'd2, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{32'h200, 1'b1, 3'd2, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
    vecs[2] = '{32'h003, 1'b0, 3'd0, 32'h0,        32'h12345678, 1'b1, 1'b0, 32'h12345678};
    vecs[3] = '{32'h002, 1'b0, 3'd1, 32'h0,        32'h0BAD0BAD, 1'b1, 1'b0, 32'h0BAD0BAD};
    vecs[4] = '{32'h001, 1'b0, 3'd1, 32'h0,        32'h5A5A5A5A, 1'b0, 1'b1, 32'h0};
    vecs[5] = '{32'h002, 1'b0, 3'd2, 32'h0,        32'h5A5A5A5A, 1'b0, 1'b1, 32'h0};
    vecs[6] = '{32'h000, 1'b1, 3'd3, 32'h77,       32'h5A5A5A5A, 1'b0, 1'b1, 32'h0};
    vecs[7] = '{32'h080, 1'b0, 3'd7, 32'h0,        32'h5A5A5A5A, 1'b0, 1'b1, 32'h0};

    HRESET = 1'b1;
    req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_size = '0;
    req_nonsec = 1'b0; req_wdata = '0;
    bus_okay();

    // Reset state
    repeat (2) @(negedge HCLK);
    chk("rst_htrans", 64'(HTRANS), 64'(0));
    chk("rst_haddr", 64'(HADDR), 64'(0));
    chk("rst_hwdata", 64'(HWDATA), 64'(0));
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_hburst", 64'(HBURST), 64'(0));
    HRESET = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back writes
    @(negedge HCLK); drive_req(32'h0, 1'b1, 3'd2, 32'h11);
    @(negedge HCLK);
    chk("b2b_t0", 64'(HTRANS), 64'(2)); chk("b2b_a0", 64'(HADDR), 64'(0));
    drive_req(32'h4, 1'b1, 3'd2, 32'h22);
    #1 chk("b2b_ready", 64'(req_ready), 64'(1));
    @(negedge HCLK);
    req_valid = 1'b0;
    chk("b2b_t1", 64'(HTRANS), 64'(2)); chk("b2b_a1", 64'(HADDR), 64'(4));
    chk("b2b_wd0", 64'(HWDATA), 64'(32'h11));
    @(negedge HCLK);
    chk("b2b_t2", 64'(HTRANS), 64'(0)); chk("b2b_wd1", 64'(HWDATA), 64'(32'h22));
    chk("b2b_r0v", 64'(rsp_valid), 64'(1)); chk("b2b_r0e", 64'(rsp_err), 64'(0));
    @(negedge HCLK);
    chk("b2b_r1v", 64'(rsp_valid), 64'(1)); chk("b2b_r1e", 64'(rsp_err), 64'(0));
    @(negedge HCLK);
    chk("b2b_idle", 64'(rsp_valid), 64'(0));

    // Read with two wait states while further requests queue up
    @(negedge HCLK); drive_req(32'h100, 1'b0, 3'd2, 32'h0);
    @(negedge HCLK); drive_req(32'h104, 1'b0, 3'd2, 32'h0);
    @(negedge HCLK); drive_req(32'h108, 1'b0, 3'd2, 32'h0); HREADY = 1'b0;
    #1 chk("ws_ready0", 64'(req_ready), 64'(0));
    chk("ws_t0", 64'(HTRANS), 64'(2)); chk("ws_a0", 64'(HADDR), 64'(32'h104));
    @(negedge HCLK); HREADY = 1'b0;
    #1 chk("ws_ready1", 64'(req_ready), 64'(0));
    chk("ws_t1", 64'(HTRANS), 64'(2)); chk("ws_a1", 64'(HADDR), 64'(32'h104));
    chk("ws_norsp", 64'(rsp_valid), 64'(0));
    @(negedge HCLK); HREADY = 1'b1; HRDATA = 32'hA1;
    #1 chk("ws_ready2", 64'(req_ready), 64'(1));
    @(negedge HCLK); req_valid = 1'b0; HRDATA = 32'hA2;
    chk("ws_r1v", 64'(rsp_valid), 64'(1)); chk("ws_r1d", 64'(rsp_rdata), 64'(32'hA1));
    chk("ws_t2", 64'(HTRANS), 64'(2)); chk("ws_a2", 64'(HADDR), 64'(32'h108));
    @(negedge HCLK); HRDATA = 32'hA3;
    chk("ws_r2v", 64'(rsp_valid), 64'(1)); chk("ws_r2d", 64'(rsp_rdata), 64'(32'hA2));
    chk("ws_t3", 64'(HTRANS), 64'(0));
    @(negedge HCLK); HRDATA = '0;
    chk("ws_r3v", 64'(rsp_valid), 64'(1)); chk("ws_r3d", 64'(rsp_rdata), 64'(32'hA3));

    // Two-cycle ERROR on a write with a second write in the address phase
    @(negedge HCLK); drive_req(32'h10, 1'b1, 3'd2, 32'h1);
    @(negedge HCLK); drive_req(32'h14, 1'b1, 3'd2, 32'h2);
    @(negedge HCLK); req_valid = 1'b0; HREADY = 1'b0; HRESP = 1'b1;
    chk("er_t0", 64'(HTRANS), 64'(2)); chk("er_a0", 64'(HADDR), 64'(32'h14));
    chk("er_wd", 64'(HWDATA), 64'(1));
    @(negedge HCLK); HREADY = 1'b1; HRESP = 1'b1;
    chk("er_t1", 64'(HTRANS), 64'(2)); chk("er_a1", 64'(HADDR), 64'(32'h14));
    chk("er_norsp", 64'(rsp_valid), 64'(0));
    @(negedge HCLK); HRESP = 1'b0;
    chk("er_r1v", 64'(rsp_valid), 64'(1)); chk("er_r1e", 64'(rsp_err), 64'(1));
    chk("er_r1d", 64'(rsp_rdata), 64'(0));
    @(negedge HCLK);
    chk("er_r2v", 64'(rsp_valid), 64'(1)); chk("er_r2e", 64'(rsp_err), 64'(0));
    @(negedge HCLK);
    chk("er_idle", 64'(rsp_valid), 64'(0));

    // Order preserved: bus read followed directly by a rejected request
    @(negedge HCLK); drive_req(32'h40, 1'b0, 3'd2, 32'h0);
    @(negedge HCLK); drive_req(32'h44, 1'b0, 3'd3, 32'h0);
    @(negedge HCLK); req_valid = 1'b0; HRDATA = 32'h55;
    chk("ord_t_tok", 64'(HTRANS), 64'(0));
    @(negedge HCLK); HRDATA = 32'h99;
    chk("ord_r1e", 64'(rsp_err), 64'(0)); chk("ord_r1d", 64'(rsp_rdata), 64'(32'h55));
    @(negedge HCLK); HRDATA = '0;
    chk("ord_r2v", 64'(rsp_valid), 64'(1)); chk("ord_r2e", 64'(rsp_err), 64'(1));
    chk("ord_r2d", 64'(rsp_rdata), 64'(0));

    // Reset during a wait-stated data phase
    @(negedge HCLK); drive_req(32'h80, 1'b0, 3'd2, 32'h0);
    @(negedge HCLK); req_valid = 1'b0;
    @(negedge HCLK); HREADY = 1'b0;
    @(negedge HCLK); HRESET = 1'b1;
    #1 chk("mr_htrans", 64'(HTRANS), 64'(0)); chk("mr_rsp", 64'(rsp_valid), 64'(0));
    chk("mr_ready", 64'(req_ready), 64'(0));
    @(negedge HCLK); HRESET = 1'b0; HREADY = 1'b1;
    @(negedge HCLK); chk("mr_norsp0", 64'(rsp_valid), 64'(0));
    @(negedge HCLK); chk("mr_norsp1", 64'(rsp_valid), 64'(0));
    run_vec(vecs[0], "mr_after");

    // Random traffic against a transaction-level model
    begin
      bus_t dp;
      logic dp_act = 1'b0;
      int   dp_wait = 0;
      logic err_second = 1'b0;
      logic pend = 1'b0;
      logic prev_hready = 1'b1;
      logic [1:0] prev_htrans = 2'b00;
      logic [31:0] prev_haddr = '0;
      logic prev_hwrite = 1'b0;
      logic [2:0] prev_hsize = '0;
      for (int cyc = 0; cyc < 3300; cyc++) begin
        logic cap, done, acc, illegal;
        @(negedge HCLK);
        if (rsp_valid) begin
          if (rsp_q.size() == 0) chk("rnd_rsp_unexpected", 64'(1), 64'(0));
          else begin
            rsp_t r;
            r = rsp_q.pop_front();
            chk("rnd_rsp_err", 64'(rsp_err), 64'(r.err));
            chk("rnd_rsp_rdata", 64'(rsp_rdata), 64'(r.rdata));
          end
        end
        if (!prev_hready && prev_htrans == 2'b10) begin
          chk("rnd_hold_htrans", 64'(HTRANS), 64'(prev_htrans));
          chk("rnd_hold_haddr", 64'(HADDR), 64'(prev_haddr));
          chk("rnd_hold_hwrite", 64'(HWRITE), 64'(prev_hwrite));
          chk("rnd_hold_hsize", 64'(HSIZE), 64'(prev_hsize));
        end
        if (HTRANS != 2'b00 && HTRANS != 2'b10) chk("rnd_htrans_legal", 64'(HTRANS), 64'(2));
        if (dp_act && dp.write) chk("rnd_hwdata", 64'(HWDATA), 64'(dp.wdata));

        HRESP  = 1'b0;
        HRDATA = $urandom;
        if (!dp_act) HREADY = 1'b1;
        else if (dp_wait > 0) begin HREADY = 1'b0; dp_wait--; end
        else if (dp.err && !err_second) begin HREADY = 1'b0; HRESP = 1'b1; err_second = 1'b1; end
        else begin
          HREADY = 1'b1; HRESP = dp.err;
          if (!dp.err) HRDATA = dp.rdata;
        end

        if (!pend) begin
          if (cyc < 3000 && $urandom_range(0, 99) < 60) begin
            logic [2:0] s;
            logic [31:0] a;
            s = 3'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) s = 3'($urandom_range(4, 7));
            a = $urandom & 32'h0000_FFFF;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 32'd1);
            drive_req(a, 1'($urandom), s, $urandom);
            req_nonsec = 1'($urandom);
            pend = 1'b1;
          end else req_valid = 1'b0;
        end

        #1;
        cap  = (HTRANS == 2'b10) && HREADY;
        done = dp_act && HREADY;
        acc  = req_valid && req_ready;
        prev_hready = HREADY; prev_htrans = HTRANS; prev_haddr = HADDR;
        prev_hwrite = HWRITE; prev_hsize = HSIZE;
        if (done) begin dp_act = 1'b0; err_second = 1'b0; end
        if (cap) begin
          if (bus_q.size() == 0) chk("rnd_bus_unexpected", 64'(1), 64'(0));
          else begin
            dp = bus_q.pop_front();
            chk("rnd_haddr", 64'(HADDR), 64'(dp.addr));
            chk("rnd_hwrite", 64'(HWRITE), 64'(dp.write));
            chk("rnd_hsize", 64'(HSIZE), 64'(dp.size));
            chk("rnd_hnonsec", 64'(HNONSEC), 64'(0));
            dp_act = 1'b1; dp_wait = dp.waits; err_second = 1'b0;
          end
        end
        if (acc) begin
          bus_t b;
          rsp_t r;
          illegal = (req_size > 3'd2) || ((req_addr % (32'd1 << req_size)) != 0);
          b.addr = req_addr; b.write = req_write; b.size = req_size; b.wdata = req_wdata;
          b.err = ($urandom_range(0, 7) == 0);
          b.rdata = $urandom;
          b.waits = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
          r.err = illegal || b.err;
          r.rdata = (!illegal && !b.err && !b.write) ? b.rdata : 32'h0;
          rsp_q.push_back(r);
          if (!illegal) bus_q.push_back(b);
          pend = 1'b0;
        end
      end
      chk("rnd_rsp_drained", 64'(rsp_q.size()), 64'(0));
      chk("rnd_bus_drained", 64'(bus_q.size()), 64'(0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
